pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8'd255: max MEM_WAIT cycles before halt.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 id_rs1, id_rs2  input  4 each  source register numbers of the instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-006 ex_reg_dst  input  4  destination register of the instruction in EX.
REQ-007 ex_reg_wr, ex_mem_rd  input  1 each  EX instruction writes a register / is a load.
REQ-008 branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-009 mem_req, mem_ready  input  1 each  MEM-stage access active / data memory completes this cycle.
REQ-010 halt_req  input  1  request to halt the pipeline.
REQ-011 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  output  1 each  hold PC or the named pipeline register.
REQ-012 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  clear the named pipeline register to a bubble.
REQ-013 halted, mem_err  output  1 each  pipeline halted / halt caused by memory timeout (sticky).
REQ-014 stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-015 State register with states RUN, MEM_WAIT, HALTED; all stall/flush outputs combinational from state and current inputs, so they act in the same cycle.
REQ-016 Priority per cycle: HALTED > memory wait > branch flush > load-use stall; a lower-priority condition contributes no outputs in a cycle where a higher one is active.
REQ-017 Memory wait (RUN with mem_req=1, mem_ready=0, or MEM_WAIT with mem_ready=0): pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1; all other outputs 0.
REQ-018 RUN, mem_req=1, mem_ready=0 -> next state MEM_WAIT, wait_cnt = 1.
REQ-019 MEM_WAIT, mem_ready=0 -> wait_cnt increments; when wait_cnt == MEM_TIMEOUT and mem_ready=0, next state HALTED and mem_err <= 1.
REQ-020 MEM_WAIT, mem_ready=1 -> no memory-wait outputs this cycle; RUN rules (REQ-021..023) evaluate; next state RUN, wait_cnt cleared.
REQ-021 Branch flush (branch_taken=1): if_id_flush = 1, id_ex_flush = 1, no stalls; ignored while a memory wait is active, so it is honored on the release cycle.
REQ-022 Load-use hazard: ex_mem_rd & ex_reg_wr & ((id_use_rs1 & id_rs1==ex_reg_dst) | (id_use_rs2 & id_rs2==ex_reg_dst)); response pc_stall = 1, if_id_stall = 1, id_ex_flush = 1 for that cycle only. Register 0 gets no special treatment.
REQ-023 No condition active: all stall/flush outputs 0.
REQ-024 halt_req=1 in RUN or MEM_WAIT -> next state HALTED; mem_err unchanged.
REQ-025 HALTED: all five stalls = 1, mem_wb_flush = 1, other flushes 0, halted = 1; exit only through reset.
REQ-026 ex_mem_flush is 0 in all states; it exists for interface completeness.
REQ-027 stall_cnt increments each cycle pc_stall=1; flush_cnt increments each cycle if_id_flush=1; both saturate at 16'hFFFF, no wrap.
REQ-028 Timeout and halt_req in the same cycle -> HALTED with mem_err = 1.

Reset
REQ-029 rst_n=0 asynchronously forces state RUN, wait_cnt 0, mem_err 0, stall_cnt 0, flush_cnt 0; this applies mid-wait or while halted.
REQ-030 During reset and on the first cycle after it, with all inputs 0, every stall/flush output and halted read 0.

Verification
REQ-031 Load-use: ex_mem_rd=1, ex_reg_wr=1, ex_reg_dst=5, id_use_rs2=1, id_rs2=5 for one cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only; stall_cnt=1.
REQ-032 Memory wait: mem_req=1, mem_ready low for 3 cycles, then high -> 3 cycles of four stalls plus mem_wb_flush; release cycle all 0; state returns to RUN.
REQ-033 Priority: branch_taken=1 together with a load-use match -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt increments by 1.
REQ-034 Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> HALTED after 4 wait cycles; halted=1, mem_err=1; all stalls held until rst_n pulse, then all 0.
REQ-035 Saturation: force 70000 consecutive stall cycles -> stall_cnt holds 16'hFFFF.
REQ-036 Reset mid-MEM_WAIT: assert rst_n=0 between clock edges -> outputs drop to 0 and counters clear before the next posedge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller.
// Resolves, in one cycle, the stall and flush controls for a five-stage
// pipeline from the current hazard inputs and a small RUN/MEM_WAIT/HALTED
// state machine. Also keeps saturating counts of stall and flush cycles.
module pipeline_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [3:0]  ex_reg_dst,
    input  logic        ex_reg_wr,
    input  logic        ex_mem_rd,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        halt_req,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        mem_wb_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic        r_mem_err;
    logic        w_mem_err_nxt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_mem_wait;
    logic        w_load_use;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 16'd1;
        end
    endfunction

    // Hazard detection: load-use match and whether memory is stalling this cycle.
    always_comb begin
        w_load_use = ex_mem_rd & ex_reg_wr &
                     ((id_use_rs1 & (id_rs1 == ex_reg_dst)) |
                      (id_use_rs2 & (id_rs2 == ex_reg_dst)));
        case (r_state)
            ST_RUN:      w_mem_wait = mem_req & ~mem_ready;
            ST_MEM_WAIT: w_mem_wait = ~mem_ready;
            default:     w_mem_wait = 1'b0;
        endcase
    end

    // Stall/flush outputs by priority: halted, memory wait, branch, load-use.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (r_state == ST_HALTED) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (w_mem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (w_load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end else begin
            pc_stall     = 1'b0;
        end
    end

    // Next state, wait counter and sticky memory-error flag.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        case (r_state)
            ST_RUN: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_mem_wait) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end else begin
                    w_wait_cnt_nxt = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready && (r_wait_cnt == MEM_TIMEOUT)) begin
                    // Timeout wins even when halt_req arrives in the same cycle.
                    w_state_nxt   = ST_HALTED;
                    w_mem_err_nxt = 1'b1;
                end else if (halt_req) begin
                    w_state_nxt = ST_HALTED;
                end else if (!mem_ready) begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end else begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // State, wait counter and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (pc_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (if_id_flush) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign halted    = (r_state == ST_HALTED);
    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
